operand_skew_feeder: RTL and testbench
======================================

# operand_skew_feeder

- Upstream stage of the 8x8 systolic matrix-multiply core.
- Fetches one 8x8 operand tile pair (A columns, B rows) from the operand SRAM banks into a local tile buffer. It then streams the tile to the array as 2N-1 diagonally skewed beats with zero padding, under a valid/ready handshake.
- Each skewed beat is the 4-byte-per-bank word the array consumes on its sram_rdata_a0/a1/b0/b1 inputs.

## Interface

Parameters:
- ARRAY_SIZE, 8: array dimension N (lanes per operand).
- DATA_WIDTH, 8: operand element width, signed.
- ADDR_WIDTH, 10: SRAM address width.

Ports:
- clk  in  1  clock.
- srstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to process one tile; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first SRAM word of the tile; sampled with start.
- busy  out  1  high from accepted start until the final beat handshake.
- done  out  1  one-cycle pulse after the final beat handshake.
- sram_ren  out  1  read enable to A and B banks.
- sram_raddr  out  ADDR_WIDTH  shared read address for A and B banks.
- sram_rdata_a0/a1  in  32 each  A column: lanes 0-3 and lanes 4-7; lane 0 and lane 4 are in bits [31:24].
- sram_rdata_b0/b1  in  32 each  B row: same lane packing as A.
- out_a0, out_a1, out_b0, out_b1  out  32 each  skewed beat, same lane packing.
- out_valid  out  1  beat valid.
- out_ready  in  1  array accepts the beat.
- out_last  out  1  high on beat 2N-2.

## Operation

- States: IDLE -> FETCH -> STREAM -> IDLE.
- IDLE:
  - start=1 latches base_addr, clears the fetch counter, and moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - Lasts N+1 cycles.
  - In fetch cycle f (0..N-1): sram_ren=1 and sram_raddr=base+f.
  - SRAM read latency is 1 cycle. Word f is written into tile buffer slot f at the end of fetch cycle f+1.
  - After slot N-1 is captured, move to STREAM with beat counter s=0.
- STREAM:
  - out_valid=1.
  - Lane i of each operand = buffer[s-i].lane[i] when 0 <= s-i <= N-1, otherwise 0.
  - s increments on out_valid && out_ready.
  - When out_ready=0, all out_* hold stable.
  - On the handshake with s=2N-2 (out_last=1): return to IDLE, drop busy, and pulse done in the next cycle.
- Address arithmetic is ADDR_WIDTH modulo; base+f wraps past 2^ADDR_WIDTH-1 to 0.
- The beat counter is 4 bits for N=8 and never exceeds 2N-2.
- Elements pass through unmodified: no sign extension, no arithmetic.

## Timing

- Reset values: busy=0, done=0, sram_ren=0, sram_raddr=0, out_valid=0, out_last=0, out_a*/out_b*=0; state=IDLE.
- Reset asserted mid-FETCH or mid-STREAM:
  - Aborts immediately to IDLE with all outputs at reset values.
  - The tile buffer contents are don't-care.
- Cycle 0 is the edge sampling start=1. Then:
  - sram_ren is high in cycles 1..N.
  - First out_valid is in cycle N+2, i.e. cycle 10 for N=8.
  - Minimum start-to-done = N+2+2N-1 = 25 cycles with out_ready held high.
- done and IDLE coincide. A start in the done cycle is accepted, giving back-to-back tiles with one idle cycle.
- All outputs are registered; there are no combinational paths from out_ready to out_valid or data.
- SRAM data outside the capture cycles is ignored.

## Structure

- Shared package tpu_pkg holds:
  - ARRAY_SIZE, DATA_WIDTH, SKEW_BEATS = 2*ARRAY_SIZE-1.
  - The feeder state enum {IDLE, FETCH, STREAM}.
  - A lane-pack helper (lane index to bit slice, lane 0 MSB).
- One sub-module, feeder_tile_buf:
  - N x (8N bits) storage for each of A and B, with write port (slot, data).
  - Contains the skew select, taking s and producing the four 32-bit beat words.
  - The top level keeps the FSM, counters, address, and handshake.

## Test plan

- Identity A, B=0, base=0, out_ready=1:
  - Beats 0, 2, 4, 6 give out_a0 = 0x01000000, 0x00010000, 0x00000100, 0x00000001.
  - Beats 8, 10, 12, 14 give the same sequence on out_a1.
  - All other A bytes are 0; out_last only on beat 14; done in cycle 25.
- B row t with every byte = t+1:
  - Beat 1 gives out_b0=0x02010000 and out_b1=0.
  - Beat 7 gives out_b0=0x08070605 and out_b1=0x04030201.
  - Beat 14 gives out_b0=0 and out_b1=0x00000008.
- Backpressure: out_ready low for 3 cycles at beat 5.
  - Beat-5 data holds stable throughout.
  - No beat is skipped or duplicated; done is delayed by exactly 3 cycles.
- base_addr=1020, ADDR_WIDTH=10: sram_raddr sequence is 1020, 1021, 1022, 1023, 0, 1, 2, 3.
- start pulsed during FETCH and during STREAM is ignored. A start in the done cycle starts a second tile, whose first beat appears 10 cycles later.
- srstn low during beat 6:
  - All outputs return to 0 asynchronously and busy=0.
  - A new start then produces a correct full 15-beat tile.

Source files
------------

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared constants, types and helpers for the systolic
//                matrix-multiply core front end.
//                  ARRAY_SIZE  - array dimension N (lanes per operand)
//                  DATA_WIDTH  - operand element width
//                  SKEW_BEATS  - beats in one skewed tile (2N-1)
//                  feeder_state_t - operand feeder control states
//                  lane_lsb()  - lane index to bit offset, lane 0 in the MSBs
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int ARRAY_SIZE = 8;
    localparam int DATA_WIDTH = 8;
    localparam int SKEW_BEATS = 2 * ARRAY_SIZE - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

    // Lanes are packed with lane 0 in the most significant element of a row,
    // so lane i of an N-lane row starts at bit (N-1-i)*width.
    function automatic int lane_lsb(input int lane, input int lanes, input int width);
        return (lanes - 1 - lane) * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : feeder_tile_buf
//  Description : Local tile buffer for the operand skew feeder. Holds N rows
//                of A and N rows of B (N lanes each) and produces the
//                diagonally skewed beat for a requested beat index.
//  Ports       : clk        - clock
//                wr_en      - write one slot of A and B
//                wr_slot    - slot index to write
//                wr_data_a  - A row, lane 0 in the MSBs
//                wr_data_b  - B row, lane 0 in the MSBs
//                rd_beat    - skewed beat index s (0 .. 2N-2)
//                beat_a0/a1 - A beat, lanes 0..N/2-1 / N/2..N-1
//                beat_b0/b1 - B beat, same packing
//  Revision    : 1.0 - initial release
// ============================================================================
module feeder_tile_buf #(
    parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int BEAT_W     = 4,
    parameter int SLOT_W     = 3
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [SLOT_W-1:0]                  wr_slot,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   wr_data_a,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   wr_data_b,
    input  logic [BEAT_W-1:0]                  rd_beat,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] beat_a0,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] beat_a1,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] beat_b0,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] beat_b1
);
    import tpu_pkg::*;

    localparam int c_ROW_W  = ARRAY_SIZE * DATA_WIDTH;
    localparam int c_HALF_W = c_ROW_W / 2;

    logic [c_ROW_W-1:0] r_buf_a [ARRAY_SIZE];
    logic [c_ROW_W-1:0] r_buf_b [ARRAY_SIZE];

    logic [c_ROW_W-1:0] w_beat_a;
    logic [c_ROW_W-1:0] w_beat_b;
    int                 w_idx;

    // Storage needs no reset: every slot is rewritten before a tile streams.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_buf_a[wr_slot] <= wr_data_a;
            r_buf_b[wr_slot] <= wr_data_b;
        end
    end

    // Lane i of beat s carries element i of row s-i; rows outside the tile
    // are the zero padding that forms the leading and trailing triangles.
    always_comb begin
        w_beat_a = '0;
        w_beat_b = '0;
        w_idx    = 0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_idx = int'(rd_beat) - i;
            if ((w_idx >= 0) && (w_idx < ARRAY_SIZE)) begin
                w_beat_a[lane_lsb(i, ARRAY_SIZE, DATA_WIDTH) +: DATA_WIDTH] =
                    r_buf_a[w_idx[SLOT_W-1:0]][lane_lsb(i, ARRAY_SIZE, DATA_WIDTH) +: DATA_WIDTH];
                w_beat_b[lane_lsb(i, ARRAY_SIZE, DATA_WIDTH) +: DATA_WIDTH] =
                    r_buf_b[w_idx[SLOT_W-1:0]][lane_lsb(i, ARRAY_SIZE, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign beat_a0 = w_beat_a[c_ROW_W-1 -: c_HALF_W];
    assign beat_a1 = w_beat_a[c_HALF_W-1:0];
    assign beat_b0 = w_beat_b[c_ROW_W-1 -: c_HALF_W];
    assign beat_b1 = w_beat_b[c_HALF_W-1:0];

endmodule
`default_nettype wire

// File: rtl/operand_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : operand_skew_feeder
//  Description : Upstream stage of the systolic matrix-multiply core. Fetches
//                one NxN operand tile pair (A columns, B rows) from the SRAM
//                banks into a local buffer, then streams it as 2N-1 skewed,
//                zero-padded beats under a valid/ready handshake.
//  Ports       : clk, srstn (async active-low reset)
//                start, base_addr        - tile request, honoured in IDLE
//                busy, done              - status / completion pulse
//                sram_ren, sram_raddr    - shared A/B read port
//                sram_rdata_a0/a1/b0/b1  - read data, 1-cycle latency
//                out_a0/a1/b0/b1         - skewed beat
//                out_valid, out_ready, out_last - beat handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_skew_feeder #(
    parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                               clk,
    input  logic                               srstn,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               sram_ren,
    output logic [ADDR_WIDTH-1:0]              sram_raddr,
    input  logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] sram_rdata_a0,
    input  logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] sram_rdata_a1,
    input  logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] sram_rdata_b0,
    input  logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] sram_rdata_b1,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] out_a0,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] out_a1,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] out_b0,
    output logic [ARRAY_SIZE*DATA_WIDTH/2-1:0] out_b1,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last
);
    import tpu_pkg::*;

    localparam int c_HALF_W = ARRAY_SIZE * DATA_WIDTH / 2;
    localparam int c_BEAT_W = $clog2(2 * ARRAY_SIZE - 1);
    localparam int c_FCNT_W = $clog2(ARRAY_SIZE + 1);
    localparam int c_SLOT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(2 * ARRAY_SIZE - 2);
    localparam logic [c_FCNT_W-1:0] c_FETCH_END = c_FCNT_W'(ARRAY_SIZE);

    feeder_state_t          r_state, w_state_nxt;
    logic [c_FCNT_W-1:0]    r_fetch_cnt, w_fetch_cnt_nxt;
    logic [c_BEAT_W-1:0]    r_beat, w_beat_nxt;
    logic [ADDR_WIDTH-1:0]  r_base_addr, w_base_nxt;
    logic [ADDR_WIDTH-1:0]  r_raddr, w_raddr_nxt;
    logic                   r_ren, w_ren_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_busy;
    logic [c_HALF_W-1:0]    r_out_a0, r_out_a1, r_out_b0, r_out_b1;

    logic                   w_load_beat;
    logic                   w_clear_beat;
    logic [c_BEAT_W-1:0]    w_rd_beat;
    logic                   w_wr_en;
    logic [c_SLOT_W-1:0]    w_wr_slot;
    logic [c_HALF_W-1:0]    w_beat_a0, w_beat_a1, w_beat_b0, w_beat_b1;

    // Fetch cycle f returns word f-1 (one cycle of SRAM latency), so the
    // slot being captured always trails the fetch counter by one.
    assign w_wr_slot = c_SLOT_W'(r_fetch_cnt - 1'b1);

    feeder_tile_buf #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_W     (c_BEAT_W),
        .SLOT_W     (c_SLOT_W)
    ) u_tile_buf (
        .clk        (clk),
        .wr_en      (w_wr_en),
        .wr_slot    (w_wr_slot),
        .wr_data_a  ({sram_rdata_a0, sram_rdata_a1}),
        .wr_data_b  ({sram_rdata_b0, sram_rdata_b1}),
        .rd_beat    (w_rd_beat),
        .beat_a0    (w_beat_a0),
        .beat_a1    (w_beat_a1),
        .beat_b0    (w_beat_b0),
        .beat_b1    (w_beat_b1)
    );

    // Next-state and next-output logic. All ports are registered, so the
    // beat presented after a handshake is looked up one index ahead here.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_beat_nxt      = r_beat;
        w_base_nxt      = r_base_addr;
        w_ren_nxt       = 1'b0;
        w_raddr_nxt     = r_raddr;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_done_nxt      = 1'b0;
        w_load_beat     = 1'b0;
        w_clear_beat    = 1'b0;
        w_rd_beat       = r_beat;
        w_wr_en         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = FETCH;
                    w_base_nxt      = base_addr;
                    w_fetch_cnt_nxt = '0;
                    w_ren_nxt       = 1'b1;
                    w_raddr_nxt     = base_addr;
                end
            end

            FETCH: begin
                w_wr_en = (r_fetch_cnt != '0);
                if (r_fetch_cnt == c_FETCH_END) begin
                    w_state_nxt = STREAM;
                    w_beat_nxt  = '0;
                    w_rd_beat   = '0;
                    w_load_beat = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (c_LAST_BEAT == '0);
                end else begin
                    w_fetch_cnt_nxt = r_fetch_cnt + 1'b1;
                    if ((r_fetch_cnt + 1'b1) < c_FETCH_END) begin
                        w_ren_nxt   = 1'b1;
                        w_raddr_nxt = r_base_addr + ADDR_WIDTH'(r_fetch_cnt) + ADDR_WIDTH'(1);
                    end
                end
            end

            STREAM: begin
                if (out_ready) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_nxt  = IDLE;
                        w_valid_nxt  = 1'b0;
                        w_last_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_clear_beat = 1'b1;
                    end else begin
                        w_beat_nxt  = r_beat + 1'b1;
                        w_rd_beat   = r_beat + 1'b1;
                        w_load_beat = 1'b1;
                        w_last_nxt  = ((r_beat + 1'b1) == c_LAST_BEAT);
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state     <= IDLE;
            r_fetch_cnt <= '0;
            r_beat      <= '0;
            r_base_addr <= '0;
            r_raddr     <= '0;
            r_ren       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_out_a0    <= '0;
            r_out_a1    <= '0;
            r_out_b0    <= '0;
            r_out_b1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_beat      <= w_beat_nxt;
            r_base_addr <= w_base_nxt;
            r_raddr     <= w_raddr_nxt;
            r_ren       <= w_ren_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            if (w_clear_beat) begin
                r_out_a0 <= '0;
                r_out_a1 <= '0;
                r_out_b0 <= '0;
                r_out_b1 <= '0;
            end else if (w_load_beat) begin
                r_out_a0 <= w_beat_a0;
                r_out_a1 <= w_beat_a1;
                r_out_b0 <= w_beat_b0;
                r_out_b1 <= w_beat_b1;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign sram_ren   = r_ren;
    assign sram_raddr = r_raddr;
    assign out_a0     = r_out_a0;
    assign out_a1     = r_out_a1;
    assign out_b0     = r_out_b0;
    assign out_b1     = r_out_b1;
    assign out_valid  = r_valid;
    assign out_last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_operand_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_skew_feeder
//  Description : Self-checking bench for operand_skew_feeder. A behavioural
//                SRAM supplies tiles; expected beats come from the skew rule
//                applied directly to the tile arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_skew_feeder;

    localparam int N  = 8;
    localparam int AW = 10;
    localparam int NB = 2 * N - 1;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, sram_ren, out_valid, out_last;
    logic [AW-1:0] sram_raddr;
    logic [31:0]   sram_rdata_a0, sram_rdata_a1, sram_rdata_b0, sram_rdata_b1;
    logic [31:0]   out_a0, out_a1, out_b0, out_b1;
    logic          out_ready = 1'b1;

    operand_skew_feeder #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .srstn         (srstn),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .sram_ren      (sram_ren),
        .sram_raddr    (sram_raddr),
        .sram_rdata_a0 (sram_rdata_a0),
        .sram_rdata_a1 (sram_rdata_a1),
        .sram_rdata_b0 (sram_rdata_b0),
        .sram_rdata_b1 (sram_rdata_b1),
        .out_a0        (out_a0),
        .out_a1        (out_a1),
        .out_b0        (out_b0),
        .out_b1        (out_b1),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: one-cycle read latency, random data when not read.
    logic [63:0] mem_a [1 << AW];
    logic [63:0] mem_b [1 << AW];
    always @(posedge clk) begin
        if (sram_ren) begin
            {sram_rdata_a0, sram_rdata_a1} <= mem_a[sram_raddr];
            {sram_rdata_b0, sram_rdata_b1} <= mem_b[sram_raddr];
        end else begin
            sram_rdata_a0 <= $urandom; sram_rdata_a1 <= $urandom;
            sram_rdata_b0 <= $urandom; sram_rdata_b1 <= $urandom;
        end
    end

    // Tile model: tA[f][i] is lane i of A column f, tB likewise for B rows.
    logic [7:0] tA [N][N];
    logic [7:0] tB [N][N];

    int checks = 0;
    int errors = 0;

    // Per-tile observation log filled by run_tile.
    logic [127:0] obs [32];
    bit           obs_last [32];
    int           n_beats, first_valid, done_cyc, g_start_ref, busy_gap;
    bit           busy_at_done, hold_bad, timed_out;
    int           ren_cyc_log [$];
    int           raddr_log [$];

    function automatic logic [127:0] exp_beat(input int s);
        logic [63:0] ra, rb;
        ra = '0; rb = '0;
        for (int i = 0; i < N; i++) begin
            if (s - i >= 0 && s - i < N) begin
                ra[(N-1-i)*8 +: 8] = tA[s-i][i];
                rb[(N-1-i)*8 +: 8] = tB[s-i][i];
            end
        end
        return {ra, rb};
    endfunction

    task automatic randomize_tile();
        for (int f = 0; f < N; f++)
            for (int i = 0; i < N; i++) begin
                tA[f][i] = 8'($urandom);
                tB[f][i] = 8'($urandom);
            end
    endtask

    task automatic load_mem(input logic [AW-1:0] base);
        logic [63:0] wa, wb;
        logic [AW-1:0] ad;
        for (int f = 0; f < N; f++) begin
            for (int i = 0; i < N; i++) begin
                wa[(N-1-i)*8 +: 8] = tA[f][i];
                wb[(N-1-i)*8 +: 8] = tB[f][i];
            end
            ad = base + AW'(f);
            mem_a[ad] = wa;
            mem_b[ad] = wb;
        end
    endtask

    // Drives one tile and records what the DUT does. Cycle numbers are
    // relative to the edge sampling start (that edge is cycle 0).
    task automatic run_tile(input logic [AW-1:0] base, input int stall_beat, input int stall_len,
                            input int poke_a, input int poke_b, input int rst_beat,
                            input bit chain, input logic [AW-1:0] next_base, input bit pre_started);
        int c, st_cnt, start_ref;
        logic [127:0] cur, held;
        load_mem(base);
        foreach (obs[i]) begin obs[i] = 'x; obs_last[i] = 1'b0; end
        n_beats = 0; first_valid = -1; done_cyc = -1; busy_gap = 0;
        busy_at_done = 1'b1; hold_bad = 1'b0; timed_out = 1'b0; st_cnt = 0; held = '0;
        ren_cyc_log.delete(); raddr_log.delete();
        if (pre_started) start_ref = g_start_ref;
        else begin
            @(negedge clk);
            start = 1'b1; base_addr = base; start_ref = cyc;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            c = cyc - start_ref;
            start = (c == poke_a) || (c == poke_b);
            base_addr = start ? AW'($urandom) : base_addr;
            cur = {out_a0, out_a1, out_b0, out_b1};
            if (sram_ren) begin ren_cyc_log.push_back(c); raddr_log.push_back(int'(sram_raddr)); end
            if (out_valid && first_valid < 0) first_valid = c;
            if (done) begin
                done_cyc = c; busy_at_done = busy; out_ready = 1'b1;
                if (chain) begin start = 1'b1; base_addr = next_base; g_start_ref = cyc; end
                return;
            end
            if (!busy) busy_gap++;
            if (rst_beat >= 0 && out_valid && n_beats == rst_beat) begin
                srstn = 1'b0; out_ready = 1'b1; start = 1'b0;
                #1;
                return;
            end
            if (out_valid && n_beats == stall_beat && stall_len > 0) begin
                if (st_cnt == 0) held = cur;
                else if (cur !== held) hold_bad = 1'b1;
            end
            if (out_valid && n_beats == stall_beat && st_cnt < stall_len) begin
                out_ready = 1'b0; st_cnt++;
            end else out_ready = 1'b1;
            if (out_valid && out_ready) begin
                if (n_beats < 32) begin obs[n_beats] = cur; obs_last[n_beats] = out_last; end
                n_beats++;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, sram_ren, out_valid, out_last} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 00000", {busy, done, sram_ren, out_valid, out_last});
        end
        checks++;
        if ({sram_raddr, out_a0, out_a1, out_b0, out_b1} !== '0) begin
            errors++; $display("FAIL reset_data: raddr %0d a0 %h a1 %h b0 %h b1 %h required all 0",
                               sram_raddr, out_a0, out_a1, out_b0, out_b1);
        end
        srstn = 1'b1;
    endtask

    task automatic test_identity();
        logic [31:0] ea0, ea1;
        for (int f = 0; f < N; f++)
            for (int i = 0; i < N; i++) begin tA[f][i] = (f == i) ? 8'd1 : 8'd0; tB[f][i] = 8'd0; end
        run_tile(10'd0, -1, 0, -1, -1, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (n_beats != NB || first_valid != 10 || done_cyc != 25 || timed_out) begin
            errors++; $display("FAIL identity_timing: beats %0d first %0d done %0d required 15 10 25", n_beats, first_valid, done_cyc);
        end
        checks++;
        if (busy_gap != 0 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL identity_busy: gap %0d busy_at_done %b required 0 0", busy_gap, busy_at_done);
        end
        checks++;
        if (ren_cyc_log.size() != N) begin
            errors++; $display("FAIL identity_ren_count: got %0d required %0d", ren_cyc_log.size(), N);
        end else begin
            for (int f = 0; f < N; f++)
                if (ren_cyc_log[f] != f + 1 || raddr_log[f] != f) begin
                    errors++; $display("FAIL identity_ren: read %0d cycle %0d addr %0d required %0d %0d", f, ren_cyc_log[f], raddr_log[f], f + 1, f);
                end
        end
        for (int s = 0; s < NB; s++) begin
            ea0 = (s % 2 == 0 && s < 8)  ? (32'h0100_0000 >> (4 * s))       : 32'h0;
            ea1 = (s % 2 == 0 && s >= 8) ? (32'h0100_0000 >> (4 * (s - 8))) : 32'h0;
            checks++;
            if (obs[s] !== {ea0, ea1, 64'h0} || obs_last[s] != (s == NB - 1)) begin
                errors++; $display("FAIL identity_beat %0d: got %h last %b required %h last %b", s, obs[s], obs_last[s], {ea0, ea1, 64'h0}, s == NB - 1);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, out_valid} !== 3'b0) begin
            errors++; $display("FAIL identity_after_done: done/busy/valid %b required 000", {done, busy, out_valid});
        end
    endtask

    task automatic test_b_rows();
        randomize_tile();
        for (int t = 0; t < N; t++) for (int i = 0; i < N; i++) tB[t][i] = 8'(t + 1);
        run_tile(10'd200, -1, 0, -1, -1, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (obs[1][63:0] !== 64'h0201_0000_0000_0000) begin
            errors++; $display("FAIL brows_beat1: got %h required 0201000000000000", obs[1][63:0]);
        end
        checks++;
        if (obs[7][63:0] !== 64'h0807_0605_0403_0201) begin
            errors++; $display("FAIL brows_beat7: got %h required 0807060504030201", obs[7][63:0]);
        end
        checks++;
        if (obs[14][63:0] !== 64'h0000_0000_0000_0008) begin
            errors++; $display("FAIL brows_beat14: got %h required 0000000000000008", obs[14][63:0]);
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL brows_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_backpressure();
        randomize_tile();
        run_tile(10'd300, 5, 3, -1, -1, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (hold_bad || n_beats != NB || done_cyc != 28) begin
            errors++; $display("FAIL backpressure: hold_bad %b beats %0d done %0d required 0 15 28", hold_bad, n_beats, done_cyc);
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL backpressure_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_addr_wrap();
        int exp_addr [8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
        randomize_tile();
        run_tile(10'd1020, -1, 0, -1, -1, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (raddr_log.size() != N) begin
            errors++; $display("FAIL wrap_count: got %0d required %0d", raddr_log.size(), N);
        end else begin
            for (int f = 0; f < N; f++)
                if (raddr_log[f] != exp_addr[f]) begin
                    errors++; $display("FAIL wrap_addr %0d: got %0d required %0d", f, raddr_log[f], exp_addr[f]);
                end
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL wrap_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_start_ignored();
        randomize_tile();
        run_tile(10'd400, -1, 0, 4, 15, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (n_beats != NB || done_cyc != 25 || raddr_log.size() != N || raddr_log[N-1] != 400 + N - 1) begin
            errors++; $display("FAIL start_ignored: beats %0d done %0d reads %0d required 15 25 8", n_beats, done_cyc, raddr_log.size());
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL start_ignored_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_back_to_back();
        randomize_tile();
        run_tile(10'd500, -1, 0, -1, -1, -1, 1'b1, 10'd600, 1'b0);
        checks++;
        if (done_cyc != 25 || n_beats != NB) begin
            errors++; $display("FAIL b2b_first: done %0d beats %0d required 25 15", done_cyc, n_beats);
        end
        randomize_tile();
        run_tile(10'd600, -1, 0, -1, -1, -1, 1'b0, 10'd0, 1'b1);
        checks++;
        if (first_valid != 10 || done_cyc != 25 || n_beats != NB) begin
            errors++; $display("FAIL b2b_second: first %0d done %0d beats %0d required 10 25 15", first_valid, done_cyc, n_beats);
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL b2b_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        randomize_tile();
        run_tile(10'd700, -1, 0, -1, -1, 6, 1'b0, 10'd0, 1'b0);
        checks++;
        if ({busy, done, sram_ren, out_valid, out_last, sram_raddr, out_a0, out_a1, out_b0, out_b1} !== '0) begin
            errors++; $display("FAIL reset_abort: busy %b valid %b last %b a0 %h a1 %h b0 %h b1 %h required all 0",
                               busy, out_valid, out_last, out_a0, out_a1, out_b0, out_b1);
        end
        @(negedge clk);
        srstn = 1'b1;
        randomize_tile();
        run_tile(10'd710, -1, 0, -1, -1, -1, 1'b0, 10'd0, 1'b0);
        checks++;
        if (n_beats != NB || first_valid != 10 || done_cyc != 25) begin
            errors++; $display("FAIL reset_recover: beats %0d first %0d done %0d required 15 10 25", n_beats, first_valid, done_cyc);
        end
        for (int s = 0; s < NB; s++) begin
            checks++;
            if (obs[s] !== exp_beat(s)) begin
                errors++; $display("FAIL reset_recover_beat %0d: got %h required %h", s, obs[s], exp_beat(s));
            end
        end
    endtask

    task automatic test_random();
        int sb, sl;
        logic [AW-1:0] b;
        for (int t = 0; t < 5; t++) begin
            randomize_tile();
            sb = $urandom_range(NB - 1, 0);
            sl = $urandom_range(4, 1);
            b  = AW'($urandom);
            run_tile(b, sb, sl, -1, -1, -1, 1'b0, 10'd0, 1'b0);
            checks++;
            if (n_beats != NB || done_cyc != 25 + sl || hold_bad) begin
                errors++; $display("FAIL random_%0d: beats %0d done %0d hold_bad %b required 15 %0d 0", t, n_beats, done_cyc, hold_bad, 25 + sl);
            end
            for (int s = 0; s < NB; s++) begin
                checks++;
                if (obs[s] !== exp_beat(s) || obs_last[s] != (s == NB - 1)) begin
                    errors++; $display("FAIL random_%0d_beat %0d: got %h last %b required %h", t, s, obs[s], obs_last[s], exp_beat(s));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_b_rows();
        test_backpressure();
        test_addr_wrap();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
